// File: rtl/dilithium_pkg.sv
// rtl/dilithium_pkg.sv - shared Dilithium encoder constants and bitpack FSM states
package dilithium_pkg;

    localparam int N_COEFF           = 256;
    localparam int COEFF_BITS_DEF    = 24;
    localparam int DATA_OUT_BITS_DEF = 64;

    localparam int GAMMA1_LVL2  = 17;
    localparam int GAMMA1_LVL35 = 19;
    localparam int L_LVL2       = 4;
    localparam int L_LVL3       = 5;
    localparam int L_LVL5       = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_EMIT,
        S_DONE
    } bitpack_state_e;

    function automatic int packed_words(input int l, input int n, input int cw, input int wb);
        return (l * n * cw) / wb;
    endfunction

endpackage

// File: rtl/z_bitpack_pack_accum.sv
// rtl/z_bitpack_pack_accum.sv - field-in / word-out shift accumulator with bit count
module pack_accum #(
    parameter int FIELD_W = 20,
    parameter int WORD_W  = 64,
    localparam int ACC_W  = WORD_W + FIELD_W,
    localparam int CNT_W  = $clog2(ACC_W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               in_valid_i,
    input  logic [FIELD_W-1:0] in_data_i,
    input  logic               out_ready_i,
    output logic [WORD_W-1:0]  word_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam logic [CNT_W-1:0] FIELD_C = CNT_W'(FIELD_W);
    localparam logic [CNT_W-1:0] WORD_C  = CNT_W'(WORD_W);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Bits above count are always zero, so a new field can simply be ORed in.
    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        if (clear_i) begin
            acc_d   = '0;
            count_d = '0;
        end else if (in_valid_i) begin
            acc_d   = acc_q | ({{(ACC_W-FIELD_W){1'b0}}, in_data_i} << count_q);
            count_d = count_q + FIELD_C;
        end else if (out_ready_i) begin
            acc_d   = acc_q >> WORD_W;
            count_d = count_q - WORD_C;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    assign word_o  = acc_q[WORD_W-1:0];
    assign count_o = count_q;

endmodule

// File: rtl/z_bitpack.sv
// rtl/z_bitpack.sv - packs gamma1 - z coefficients from RAM into a LSB-first word stream
module z_bitpack
    import dilithium_pkg::*;
#(
    parameter int L             = L_LVL5,
    parameter int N             = N_COEFF,
    parameter int GAMMA1        = GAMMA1_LVL35,
    parameter int COEFF_WIDTH   = GAMMA1 + 1,
    parameter int COEFF_BITS    = COEFF_BITS_DEF,
    parameter int DATA_OUT_BITS = DATA_OUT_BITS_DEF,
    parameter int ADDR_WIDTH    = $clog2(L * N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_WIDTH-1:0]    rd_addr,
    input  logic [COEFF_BITS-1:0]    rd_data,
    output logic [DATA_OUT_BITS-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    localparam int NUM_COEFF = L * N;
    localparam int NUM_WORDS = packed_words(L, N, COEFF_WIDTH, DATA_OUT_BITS);
    localparam int IDX_W     = $clog2(NUM_COEFF + 1);
    localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
    localparam int CNT_W     = $clog2(DATA_OUT_BITS + COEFF_WIDTH + 1);

    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_COEFF - 1);
    localparam logic [WCNT_W-1:0]     LAST_WORD  = WCNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0]      FIELD_C    = CNT_W'(COEFF_WIDTH);
    localparam logic [CNT_W-1:0]      WORD_C     = CNT_W'(DATA_OUT_BITS);
    localparam logic [COEFF_BITS:0]   GAMMA1_VAL = {{COEFF_BITS{1'b0}}, 1'b1} << GAMMA1;

    if ((NUM_COEFF * COEFF_WIDTH) % DATA_OUT_BITS != 0) begin : g_bad_geometry
        $error("z_bitpack: L*N*COEFF_WIDTH must be a multiple of DATA_OUT_BITS");
    end

    bitpack_state_e          state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [WCNT_W-1:0]       word_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic                    busy_q, done_q, valid_q, last_q;

    logic [COEFF_WIDTH-1:0]  field;
    logic [CNT_W-1:0]        acc_count;
    logic                    acc_clear, acc_push, acc_pop, fills, still_full;

    // Out-of-range coefficients are not trapped; only the low field bits survive.
    assign field = COEFF_WIDTH'(GAMMA1_VAL - {rd_data[COEFF_BITS-1], rd_data});

    assign acc_clear  = (state_q == S_IDLE) && start;
    assign acc_push   = (state_q == S_DATA);
    assign acc_pop    = (state_q == S_EMIT) && valid_q && out_ready;
    assign fills      = (acc_count + FIELD_C) >= WORD_C;
    assign still_full = (acc_count - WORD_C) >= WORD_C;

    pack_accum #(
        .FIELD_W (COEFF_WIDTH),
        .WORD_W  (DATA_OUT_BITS)
    ) u_accum (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (acc_clear),
        .in_valid_i  (acc_push),
        .in_data_i   (field),
        .out_ready_i (acc_pop),
        .word_o      (out_data),
        .count_o     (acc_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            word_q    <= '0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_ADDR;
                        busy_q    <= 1'b1;
                        idx_q     <= '0;
                        word_q    <= '0;
                        rd_addr_q <= '0;
                    end
                end
                S_ADDR: state_q <= S_DATA;
                S_DATA: begin
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q != LAST_IDX) rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
                    if (fills) begin
                        state_q <= S_EMIT;
                        valid_q <= 1'b1;
                        last_q  <= (word_q == LAST_WORD);
                    end else if (idx_q != LAST_IDX) begin
                        state_q <= S_ADDR;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        word_q  <= word_q + WCNT_W'(1);
                        if (last_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (still_full) begin
                            valid_q <= 1'b1;
                            last_q  <= ((word_q + WCNT_W'(1)) == LAST_WORD);
                        end else begin
                            state_q <= S_ADDR;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_z_bitpack.sv
// tb/tb_z_bitpack.sv - scoreboard bench for z_bitpack at L=7/GAMMA1=19 and L=4/GAMMA1=17
module tb_z_bitpack;

    logic clk;
    logic rst;
    logic start;
    logic out_ready;
    logic sel;

    logic        busy7, done7, valid7, last7;
    logic [10:0] addr7;
    logic [23:0] rdata7;
    logic [63:0] data7;

    logic        busy6, done6, valid6, last6;
    logic [9:0]  addr6;
    logic [23:0] rdata6;
    logic [63:0] data6;

    logic [23:0] mem7 [0:2047];
    logic [23:0] mem4 [0:1023];

    logic [63:0] exp_q [$];
    int errors;
    int checks;

    wire        start7  = start & ~sel;
    wire        start6  = start & sel;
    wire        m_busy  = sel ? busy6  : busy7;
    wire        m_done  = sel ? done6  : done7;
    wire        m_valid = sel ? valid6 : valid7;
    wire        m_last  = sel ? last6  : last7;
    wire [63:0] m_data  = sel ? data6  : data7;
    wire [10:0] m_addr  = sel ? {1'b0, addr6} : addr7;

    z_bitpack #(.L(7), .GAMMA1(19)) dut7 (
        .clk(clk), .rst(rst), .start(start7), .busy(busy7), .done(done7),
        .rd_addr(addr7), .rd_data(rdata7), .out_data(data7), .out_valid(valid7),
        .out_ready(out_ready), .out_last(last7)
    );

    z_bitpack #(.L(4), .GAMMA1(17)) dut6 (
        .clk(clk), .rst(rst), .start(start6), .busy(busy6), .done(done6),
        .rd_addr(addr6), .rd_data(rdata6), .out_data(data6), .out_valid(valid6),
        .out_ready(out_ready), .out_last(last6)
    );

    always_ff @(posedge clk) begin
        rdata7 <= mem7[addr7];
        rdata6 <= mem4[addr6];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Golden model: walk the stream bit by bit, independent of any shift-accumulator structure.
    task automatic build_expected(input int nl, input int g1);
        longint      z, field;
        int          cw, pos;
        logic [63:0] w;
        cw  = g1 + 1;
        pos = 0;
        w   = '0;
        exp_q.delete();
        for (int i = 0; i < nl * 256; i++) begin
            z     = sel ? $signed(mem4[i]) : $signed(mem7[i]);
            field = ((64'sd1 <<< g1) - z) & ((64'sd1 <<< cw) - 1);
            for (int b = 0; b < cw; b++) begin
                w[pos % 64] = field[b];
                if (pos % 64 == 63) begin
                    exp_q.push_back(w);
                    w = '0;
                end
                pos++;
            end
        end
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {63'd0, m_busy}, 64'd1);
    endtask

    task automatic consume(input int total, input int stall_word, input int abort_word,
                           input int restart_word, input bit rnd, input logic [63:0] word0);
        int          got, cyc, stall_left, dones;
        logic [63:0] snap_d, expw;
        logic [10:0] snap_a;
        bit          aborted;
        got = 0; cyc = 0; stall_left = 10; dones = 0; aborted = 0;
        snap_d = '0; snap_a = '0;
        while (got < total && cyc < 20000 && !aborted) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (m_done) dones++;
            if (abort_word >= 0 && got == abort_word + 1) begin
                rst       = 1'b1;
                out_ready = 1'b1;
                @(negedge clk);
                chk("abort_busy",  {63'd0, m_busy},  64'd0);
                chk("abort_done",  {63'd0, m_done},  64'd0);
                chk("abort_valid", {63'd0, m_valid}, 64'd0);
                chk("abort_last",  {63'd0, m_last},  64'd0);
                chk("abort_data",  m_data, 64'd0);
                chk("abort_addr",  {53'd0, m_addr}, 64'd0);
                rst = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (m_done) dones++;
                end
                chk("abort_no_done", 64'(dones), 64'd0);
                aborted = 1;
            end else begin
                if (m_valid && got == stall_word && stall_left > 0) begin
                    if (stall_left == 10) begin
                        snap_d = m_data;
                        snap_a = m_addr;
                    end else begin
                        chk("stall_data", m_data, snap_d);
                        chk("stall_addr", {53'd0, m_addr}, {53'd0, snap_a});
                        chk("stall_valid", {63'd0, m_valid}, 64'd1);
                    end
                    stall_left--;
                    out_ready = 1'b0;
                end else begin
                    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (m_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_empty", 64'(got), 64'(total));
                        expw = '0;
                    end else begin
                        expw = exp_q.pop_front();
                    end
                    chk($sformatf("word%0d", got), m_data, expw);
                    chk($sformatf("last%0d", got), {63'd0, m_last}, {63'd0, (got == total - 1)});
                    if (got == 0) chk("word0_const", m_data, word0);
                    if (got == restart_word) start = 1'b1;
                    got++;
                end
            end
        end
        if (!aborted) begin
            chk("word_count", 64'(got), 64'(total));
            chk("no_early_done", 64'(dones), 64'd0);
            @(negedge clk);
            chk("done_pulse", {63'd0, m_done}, 64'd1);
            chk("busy_at_done", {63'd0, m_busy}, 64'd0);
            @(negedge clk);
            chk("done_cleared", {63'd0, m_done}, 64'd0);
            chk("valid_idle", {63'd0, m_valid}, 64'd0);
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; sel = 1'b0;
        for (int i = 0; i < 2048; i++) mem7[i] = '0;
        for (int i = 0; i < 1024; i++) mem4[i] = '0;
        // start in the reset cycle must be ignored
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("rst_busy",  {63'd0, m_busy},  64'd0);
        chk("rst_done",  {63'd0, m_done},  64'd0);
        chk("rst_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_last",  {63'd0, m_last},  64'd0);
        chk("rst_data",  m_data, 64'd0);
        chk("rst_addr",  {53'd0, m_addr}, 64'd0);

        // all zero coefficients
        build_expected(7, 19);
        kick();
        consume(560, -1, -1, -1, 0, 64'h0800008000080000);

        // extreme coefficients at the start of the vector
        mem7[0] = 24'h080000;
        mem7[1] = 24'hF80001;
        build_expected(7, 19);
        kick();
        consume(560, -1, -1, -1, 0, 64'h080000FFFFF00000);
        mem7[0] = '0;
        mem7[1] = '0;

        // backpressure on word 3
        build_expected(7, 19);
        kick();
        consume(560, 3, -1, -1, 0, 64'h0800008000080000);

        // abort after word 100, then a clean rerun
        build_expected(7, 19);
        kick();
        consume(560, -1, 100, -1, 0, 64'h0800008000080000);
        build_expected(7, 19);
        kick();
        consume(560, -1, -1, -1, 0, 64'h0800008000080000);

        // start while busy is ignored
        build_expected(7, 19);
        kick();
        consume(560, -1, -1, 50, 0, 64'h0800008000080000);

        // random coefficients with random backpressure, L=7
        for (int i = 0; i < 1792; i++)
            mem7[i] = 24'($signed($urandom_range(0, 2 * 524288 - 1)) - 524287);
        build_expected(7, 19);
        kick();
        consume(560, -1, -1, -1, 1, exp_q[0]);

        // smaller parameter set
        sel = 1'b1;
        build_expected(4, 17);
        kick();
        consume(288, -1, -1, -1, 0, 64'h0020000800020000);
        for (int i = 0; i < 1024; i++)
            mem4[i] = 24'($signed($urandom_range(0, 2 * 131072 - 1)) - 131071);
        build_expected(4, 17);
        kick();
        consume(288, -1, -1, -1, 1, exp_q[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
